alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Front-end controller for the 8-bit ALU (adder/sub, OR, AND; combinational, instantiated beside this block).
//  Accepts one command at a time over a valid/ready interface and drives the ALU operand and select lines.
//  Captures the result with zero/carry flags and returns it over a valid/ready response interface.
//  Adds a multi-cycle 8x8->16 unsigned multiply, sequenced as shift-add through the ALU adder.
// PARAMETERS
//  W        8  operand width; must equal the attached ALU width
//  CNT_W    3  multiply iteration counter width; must equal clog2(W)
// PORTS
//  clk        in   1     single clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  cmd_valid  in   1     command present
//  cmd_ready  out  1     block can accept a command (high only in IDLE)
//  cmd_op     in   3     000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, others illegal
//  cmd_a      in   W     operand A / multiplicand
//  cmd_b      in   W     operand B / multiplier
//  alu_a      out  W     to ALU input a
//  alu_b      out  W     to ALU input b
//  alu_ctrl   out  2     ALU ctrl; bit0=1 inverts b and injects carry-in (SUB), bit1 always 0
//  alu_ctrl2  out  3     ALU result select: 000 adder, 001 OR, 010 AND
//  alu_y      in   W     ALU result
//  alu_cout   in   1     ALU carry-out (LSB of ALU cout bus)
//  rsp_valid  out  1     response held until taken
//  rsp_ready  in   1     consumer accepts response
//  rsp_result out  2W    result; ALU ops zero-extended, MUL full product
//  rsp_zero   out  1     rsp_result == 0
//  rsp_carry  out  1     ADD: carry-out; SUB: carry-out (1 = no borrow); AND/OR/MUL/illegal: 0
//  rsp_err    out  1     illegal opcode
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; cmd_ready=1; rsp_valid=0; rsp_result=0; rsp_zero/carry/err=0.
//    alu_a=alu_b=0, alu_ctrl=00, alu_ctrl2=000; counters/acc cleared. Release takes effect on next edge.
//  FSM IDLE -> EXEC (ADD/SUB/AND/OR/illegal) | MUL (op 100) on cmd_valid&cmd_ready; operands+op latched.
//  EXEC (1 cycle): alu_a/alu_b = latched A/B, ctrl/ctrl2 per op.
//    On the edge, alu_y and alu_cout are captured into the response -> DONE.
//    Illegal op: ALU ignored, result 0, err=1, zero=1.
//  MUL: acc_hi(W)=0, q=B, m=A, cnt=0 on entry. Each cycle alu_a=acc_hi, alu_b=m, ctrl=00, ctrl2=000.
//    If q[0]: {c,acc_hi}={alu_cout,alu_y}, else c=0 and acc_hi is held.
//    Then {acc_hi,q} <= {c,acc_hi,q}>>1 (c shifts into MSB); cnt++.
//    After cnt==W-1 iteration (exactly W cycles) -> DONE with result {acc_hi,q}.
//  DONE: rsp_valid=1, outputs stable until rsp_valid&rsp_ready edge -> IDLE.
//    ALU lines return to 0/00/000 outside EXEC/MUL.
//  Latency: rsp_valid rises 1 cycle after accept edge for ALU ops, W cycles after for MUL.
//    Back-to-back throughput: ALU op every 3 cycles with rsp_ready tied high.
//  cmd_ready=0 in EXEC/MUL/DONE; cmd_valid there is ignored (no queueing). cmd_* may change freely after accept.
//  rsp_ready high outside DONE has no effect. rsp_ready low holds DONE indefinitely, no value change.
//  Reset mid-MUL or mid-DONE: pending op and response discarded, no rsp_valid pulse after release.
//  Widths: ADD/SUB W-bit wrap; carry reported separately. MUL never overflows 2W.
// TESTING
//  ADD a=7F b=01 -> result 0080, zero=0, carry=0, err=0; rsp_valid 1 cycle after accept; alu_ctrl2=000 in EXEC.
//  SUB a=05 b=05 -> result 0000, zero=1, carry=1; SUB a=03 b=05 -> result 00FE, carry=0; alu_ctrl=01 in EXEC.
//  AND a=F0 b=3C -> 0030; OR a=F0 b=0C -> 00FC; carry=0 for both.
//  MUL FF*FF -> FE01 after 8 MUL cycles; MUL 00*AB -> 0000 zero=1; MUL 10*10 -> 0100.
//  op=111 -> err=1, result 0000; rsp_ready low 5 cycles: rsp_valid and data held, cmd_ready=0 throughout.
//  rst_n low at MUL cycle 4 -> all outputs at reset values immediately; after release: cmd_ready=1, no rsp_valid.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command/response handshake bundle for the ALU op sequencer
interface alu_op_sequencer_if #(
    parameter int W = 8
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_result;
    logic           rsp_zero;
    logic           rsp_carry;
    logic           rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU front-end controller with shift-add 8x8 multiply
module alu_op_sequencer #(
    parameter int W     = 8,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.slave   bus,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [1:0]          alu_ctrl,
    output logic [2:0]          alu_ctrl2,
    input  logic [W-1:0]        alu_y,
    input  logic                alu_cout
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2:0]         op_q;
    logic [W-1:0]       a_q;     // operand A, doubles as multiplicand
    logic [W-1:0]       b_q;     // operand B, doubles as multiplier shift register q
    logic [W-1:0]       acc_hi;
    logic [CNT_W-1:0]   cnt;
    logic [W:0]         add_sel;
    logic [2*W-1:0]     mul_shift;
    logic               mul_last;
    logic               op_legal;

    // One multiply iteration: conditionally take the adder sum, then shift {c,acc_hi,q} right
    always_comb begin
        add_sel   = b_q[0] ? {alu_cout, alu_y} : {1'b0, acc_hi};
        mul_shift = {add_sel, b_q[W-1:1]};
        mul_last  = (cnt == CNT_W'(W - 1));
        op_legal  = (op_q <= OP_OR);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and ALU/handshake outputs; ALU lines idle at zero outside EXEC/MUL
    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        alu_ctrl      = 2'b00;
        alu_ctrl2     = 3'b000;
        case (state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_next = (bus.cmd_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                alu_a = a_q;
                alu_b = b_q;
                if (op_q == OP_SUB) alu_ctrl  = 2'b01;
                if (op_q == OP_OR)  alu_ctrl2 = 3'b001;
                if (op_q == OP_AND) alu_ctrl2 = 3'b010;
                state_next = S_DONE;
            end
            S_MUL: begin
                alu_a = acc_hi;
                alu_b = a_q;
                if (mul_last) state_next = S_DONE;
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, multiply iteration state and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            acc_hi         <= '0;
            cnt            <= '0;
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q   <= bus.cmd_op;
                        a_q    <= bus.cmd_a;
                        b_q    <= bus.cmd_b;
                        acc_hi <= '0;
                        cnt    <= '0;
                    end
                end
                S_EXEC: begin
                    if (op_legal) begin
                        bus.rsp_result <= {{W{1'b0}}, alu_y};
                        bus.rsp_zero   <= (alu_y == '0);
                        bus.rsp_carry  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_cout : 1'b0;
                        bus.rsp_err    <= 1'b0;
                    end else begin
                        bus.rsp_result <= '0;
                        bus.rsp_zero   <= 1'b1;
                        bus.rsp_carry  <= 1'b0;
                        bus.rsp_err    <= 1'b1;
                    end
                end
                S_MUL: begin
                    {acc_hi, b_q} <= mul_shift;
                    cnt           <= cnt + 1'b1;
                    if (mul_last) begin
                        bus.rsp_result <= mul_shift;
                        bus.rsp_zero   <= (mul_shift == '0);
                        bus.rsp_carry  <= 1'b0;
                        bus.rsp_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized and directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [1:0]     alu_ctrl;
    logic [2:0]     alu_ctrl2;
    logic [W-1:0]   alu_y;
    logic           alu_cout;
    logic [W:0]     alu_sum;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.W(W)) bus ();

    alu_op_sequencer #(.W(W), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_ctrl2 (alu_ctrl2),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout)
    );

    // Combinational ALU attached beside the sequencer
    always_comb begin
        alu_sum  = {1'b0, alu_a} + {1'b0, (alu_ctrl[0] ? ~alu_b : alu_b)} + {{W{1'b0}}, alu_ctrl[0]};
        alu_cout = alu_sum[W];
        case (alu_ctrl2)
            3'b001:  alu_y = alu_a | alu_b;
            3'b010:  alu_y = alu_a & alu_b;
            default: alu_y = alu_sum[W-1:0];
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: what the response should be for one command
    task automatic model(input logic [2:0] op, input int a, input int b,
                         output int res, output int zero, output int carry,
                         output int err, output int lat);
        res = 0; carry = 0; err = 0; lat = 1;
        case (op)
            3'd0: begin res = (a + b) % 256; carry = (a + b) >= 256; end
            3'd1: begin res = (a - b + 256) % 256; carry = (a >= b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: begin res = a * b; lat = W; end
            default: err = 1;
        endcase
        zero = (res == 0);
    endtask

    task automatic run_op(input logic [2:0] op, input int a, input int b, input int hold);
        int res, zero, carry, err, lat, n;
        model(op, a, b, res, zero, carry, err, lat);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = W'(a);
        bus.cmd_b     = W'(b);
        check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 3'($urandom);
        bus.cmd_a     = W'($urandom);
        bus.cmd_b     = W'($urandom);
        if (op <= 3'd3) begin
            check("exec_alu_a", {24'd0, alu_a}, 32'(a));
            check("exec_alu_b", {24'd0, alu_b}, 32'(b));
            check("exec_alu_ctrl", {30'd0, alu_ctrl}, (op == 3'd1) ? 32'd1 : 32'd0);
            check("exec_alu_ctrl2", {29'd0, alu_ctrl2},
                  (op == 3'd2) ? 32'd2 : (op == 3'd3) ? 32'd1 : 32'd0);
        end
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            check("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("rsp_result", {16'd0, bus.rsp_result}, 32'(res));
        check("rsp_zero", {31'd0, bus.rsp_zero}, 32'(zero));
        check("rsp_carry", {31'd0, bus.rsp_carry}, 32'(carry));
        check("rsp_err", {31'd0, bus.rsp_err}, 32'(err));
        check("done_alu_lines", {19'd0, alu_a, alu_ctrl, alu_ctrl2}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("hold_result", {16'd0, bus.rsp_result}, 32'(res));
            check("hold_err", {31'd0, bus.rsp_err}, 32'(err));
            check("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check("rsp_taken", {31'd0, bus.rsp_valid}, 32'd0);
        check("cmd_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_bits", {13'd0, bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 32'd0);
        check("reset_alu_lines", {11'd0, alu_a, alu_b, alu_ctrl, alu_ctrl2}, 32'd0);
        rst_n = 1'b1;

        run_op(3'd0, 'h7F, 'h01, 0);
        run_op(3'd1, 'h05, 'h05, 0);
        run_op(3'd1, 'h03, 'h05, 0);
        run_op(3'd2, 'hF0, 'h3C, 0);
        run_op(3'd3, 'hF0, 'h0C, 0);
        run_op(3'd4, 'hFF, 'hFF, 0);
        run_op(3'd4, 'h00, 'hAB, 0);
        run_op(3'd4, 'h10, 'h10, 0);
        run_op(3'd7, 'h12, 'h34, 5);
        run_op(3'd0, 'hFF, 'hFF, 2);

        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd4;
        bus.cmd_a     = 8'hFF;
        bus.cmd_b     = 8'hFF;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mul_busy_before_reset", {31'd0, bus.cmd_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midmul_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("midmul_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("midmul_rsp_bits", {13'd0, bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 32'd0);
        check("midmul_alu_lines", {11'd0, alu_a, alu_b, alu_ctrl, alu_ctrl2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_reset_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        check("post_reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        bus.rsp_ready = 1'b0;
        run_op(3'd4, 'h10, 'h10, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
